// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, IMEM requests, 2-entry instruction queue.
// Optional FETCH_PERF_EN adds pop and stall counters.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [6:0]        opcode,
  output logic [31:0]       instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_instr,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    ARRANQUE,
    EJECUTA,
    VACIA
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic        inflight;
  logic [31:0] fly_pc;
  logic [1:0]  cnt;
  logic [31:0] q0_i;
  logic [31:0] q0_pc;
  logic [31:0] q1_i;
  logic [31:0] q1_pc;
  logic [31:0] last_i;
  logic [31:0] last_pc;
  logic        land;
  logic        pop;
  logic        issue;
  logic [2:0]  occ;

  // The returning IMEM word acts as a live tail entry for 1-cycle latency.
  assign land        = inflight & (state != VACIA);
  assign instr_valid = (cnt != 2'd0) | land;
  assign pop         = instr_valid & instr_ready;
  assign occ         = {1'b0, cnt} + {2'b00, inflight};
  assign imem_addr   = pc[ADDR_W+1:2];
  assign imem_rd     = issue;
  assign opcode      = instr[6:0];

  // Head select: stored entry, else landing word, else hold last shown.
  always_comb begin
    instr    = last_i;
    instr_pc = last_pc;
    if (cnt != 2'd0) begin
      instr    = q0_i;
      instr_pc = q0_pc;
    end else if (land) begin
      instr    = imem_q;
      instr_pc = fly_pc;
    end
  end

  // Next state and issue decision; redirect overrides both.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      ARRANQUE: state_nx = EJECUTA;
      EJECUTA, VACIA: begin
        state_nx = EJECUTA;
        issue    = occ < (3'd2 + {2'b00, pop});
      end
      default: state_nx = ARRANQUE;
    endcase
    if (redirect) begin
      state_nx = VACIA;
      issue    = 1'b0;
    end
  end

  // State, PC and in-flight tracking.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ARRANQUE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      fly_pc   <= '0;
    end else begin
      state <= state_nx;
      if (redirect) begin
        pc       <= redirect_pc & ~32'd3;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc     <= pc + 32'd4;
          fly_pc <= pc;
        end
      end
    end
  end

  // Queue storage: drop head on pop, append landing word if not consumed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt   <= 2'd0;
      q0_i  <= '0;
      q0_pc <= '0;
      q1_i  <= '0;
      q1_pc <= '0;
    end else if (redirect) begin
      cnt <= 2'd0;
    end else begin
      unique case (cnt)
        2'd0: begin
          if (land && !pop) begin
            q0_i  <= imem_q;
            q0_pc <= fly_pc;
            cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && land) begin
            q0_i  <= imem_q;
            q0_pc <= fly_pc;
          end else if (pop) begin
            cnt <= 2'd0;
          end else if (land) begin
            q1_i  <= imem_q;
            q1_pc <= fly_pc;
            cnt   <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            q0_i  <= q1_i;
            q0_pc <= q1_pc;
            cnt   <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

  // Remember the presented word so the outputs hold while empty.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_i  <= '0;
      last_pc <= '0;
    end else begin
      last_i  <= instr;
      last_pc <= instr_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running pop and stall counters; only RESET clears them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && !redirect)
        perf_instr <= perf_instr + 32'd1;
      if (instr_valid && !instr_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an expected-PC scoreboard.
// Perf counters are checked when FETCH_PERF_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic [9:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] instr_pc;

  logic        w_rd;
  logic [9:0]  w_addr;
  logic [31:0] w_q;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [31:0] w_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;
  logic [31:0] w_perf_instr;
  logic [31:0] w_perf_stall;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int npop = 0;
  int base;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
    .CLK(clk), .RESET(rst),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
  );

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(32'h0000_0FFC)) dut_w (
    .CLK(clk), .RESET(rst),
    .imem_rd(w_rd), .imem_addr(w_addr), .imem_q(w_q),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .opcode(w_opcode), .instr_pc(w_pc)
`ifdef FETCH_PERF_EN
    , .perf_instr(w_perf_instr), .perf_stall(w_perf_stall)
`endif
  );

  // IMEM[k] = 0x13 + k, 1-cycle synchronous read
  always @(posedge clk) begin
    if (imem_rd) imem_q <= 32'h13 + {22'b0, imem_addr};
    if (w_rd) w_q <= 32'h13 + {22'b0, w_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_of(input logic [31:0] pc);
    return 32'h13 + {22'b0, pc[11:2]};
  endfunction

  // Scoreboard: every accepted word must be the next expected PC.
  always @(negedge clk) begin
    if (!rst && !redirect && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_word", instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, mem_of(e));
        chk("sb_opcode", {25'b0, opcode}, {25'b0, mem_of(e) & 32'h7F});
        npop++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic fill_sb(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 24; i++) sb.push_back(start + 32'(4 * i));
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_rd", {31'b0, imem_rd}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", {22'b0, imem_addr}, 32'd0);
    chk("rst_waddr", {22'b0, w_addr}, 32'd1023);

    // Startup stream, ready high; wrap instance alongside
    fill_sb(32'h0);
    base = npop;
    nxt(); rst = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("arr_rd", {31'b0, imem_rd}, 32'd0);
    nxt();
    @(negedge clk);
    chk("a1_rd", {31'b0, imem_rd}, 32'd1);
    chk("a1_addr", {22'b0, imem_addr}, 32'd0);
    chk("a1_valid", {31'b0, instr_valid}, 32'd0);
    chk("w_a1_addr", {22'b0, w_addr}, 32'd1023);
    nxt();
    @(negedge clk);
    chk("a2_valid", {31'b0, instr_valid}, 32'd1);
    chk("a2_instr", instr, 32'h13);
    chk("a2_pc", instr_pc, 32'h0);
    chk("a2_addr", {22'b0, imem_addr}, 32'd1);
    chk("w_a2_addr", {22'b0, w_addr}, 32'd0);
    chk("w_a2_pc", w_pc, 32'hFFC);
    chk("w_a2_instr", w_instr, 32'h13 + 32'd1023);
    chk("w_a2_opc", {25'b0, w_opcode}, 32'h12);
    nxt();
    @(negedge clk);
    chk("a3_valid", {31'b0, instr_valid}, 32'd1);
    chk("w_a3_pc", w_pc, 32'h1000);
    chk("w_a3_instr", w_instr, 32'h13);
    nxt();
    @(negedge clk);
    chk("a4_valid", {31'b0, instr_valid}, 32'd1);
    nxt();
    @(negedge clk);
    chk("a5_valid", {31'b0, instr_valid}, 32'd1);
    nxt();
    chk("t1_pops", 32'(npop - base), 32'd4);

    // Backpressure: ready low for 5 cycles after first valid
    do_reset();
    fill_sb(32'h0);
    base = npop;
    nxt(); rst = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("bp_a2_rd", {31'b0, imem_rd}, 32'd1);
    chk("bp_a2_pc", instr_pc, 32'h0);
    nxt();
    @(negedge clk);
    chk("bp_a3_rd", {31'b0, imem_rd}, 32'd0);
    chk("bp_a3_pc", instr_pc, 32'h0);
    nxt();
    @(negedge clk);
    chk("bp_a4_rd", {31'b0, imem_rd}, 32'd0);
    chk("bp_a4_instr", instr, 32'h13);
    nxt();
    nxt();
    @(negedge clk);
    chk("bp_a6_rd", {31'b0, imem_rd}, 32'd0);
    chk("bp_a6_pc", instr_pc, 32'h0);
    chk("bp_a6_valid", {31'b0, instr_valid}, 32'd1);
    nxt(); instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) nxt();
    chk("bp_pops", 32'(npop - base), 32'd6);

    // Redirect with one queued word and one in flight
    do_reset();
    fill_sb(32'h0);
    base = npop;
    nxt(); rst = 1'b0;
    nxt();
    nxt();
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    fill_sb(32'h100);
    @(negedge clk);
    chk("rd_n_rd", {31'b0, imem_rd}, 32'd0);
    chk("rd_n_valid", {31'b0, instr_valid}, 32'd1);
    nxt(); redirect = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("rd_n1_valid", {31'b0, instr_valid}, 32'd0);
    chk("rd_n1_rd", {31'b0, imem_rd}, 32'd1);
    chk("rd_n1_addr", {22'b0, imem_addr}, 32'h40);
    nxt();
    @(negedge clk);
    chk("rd_n2_valid", {31'b0, instr_valid}, 32'd1);
    chk("rd_n2_pc", instr_pc, 32'h100);
    chk("rd_n2_instr", instr, 32'h53);
    nxt();
    nxt();
    nxt();
    chk("rd_pops", 32'(npop - base), 32'd3);

    // Redirect while streaming, then back-to-back redirects
    do_reset();
    fill_sb(32'h0);
    base = npop;
    nxt(); rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) nxt();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    fill_sb(32'h200);
    @(negedge clk);
    chk("rs_n_pc", instr_pc, 32'd16);
    chk("rs_n_valid", {31'b0, instr_valid}, 32'd1);
    chk("rs_n_rd", {31'b0, imem_rd}, 32'd0);
    nxt(); redirect = 1'b0;
    @(negedge clk);
    chk("rs_n1_valid", {31'b0, instr_valid}, 32'd0);
    chk("rs_hold_pc", instr_pc, 32'd16);
    chk("rs_hold_instr", instr, 32'h17);
    chk("rs_n1_addr", {22'b0, imem_addr}, 32'h80);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    fill_sb(32'h400);
    @(negedge clk);
    chk("bb_first_pc", instr_pc, 32'h200);
    nxt();
    redirect = 1'b1;
    redirect_pc = 32'h403;
    @(negedge clk);
    chk("bb_valid0", {31'b0, instr_valid}, 32'd0);
    chk("bb_rd0", {31'b0, imem_rd}, 32'd0);
    nxt(); redirect = 1'b0;
    @(negedge clk);
    chk("bb_valid1", {31'b0, instr_valid}, 32'd0);
    chk("bb_addr", {22'b0, imem_addr}, 32'h100);
    nxt();
    @(negedge clk);
    chk("bb_pc", instr_pc, 32'h400);
    chk("bb_instr", instr, 32'h113);
    nxt();
    nxt();
    chk("rs_pops", 32'(npop - base), 32'd6);

    // 10 pops, 3 stalls, then reset mid-run
    do_reset();
    fill_sb(32'h0);
    base = npop;
    nxt(); rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) nxt();
    nxt(); instr_ready = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("st_pc", instr_pc, 32'd20);
    nxt(); instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    nxt(); instr_ready = 1'b0;
    @(negedge clk);
    chk("pf_pops", 32'(npop - base), 32'd10);
`ifdef FETCH_PERF_EN
    chk("perf_instr", perf_instr, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif
    nxt(); rst = 1'b1;
    nxt();
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    chk("mid_rst_rd", {31'b0, imem_rd}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_instr_rst", perf_instr, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
